// File: rtl/pipelined_shifter_if.sv
// Request/result bundle for pipelined_shifter: valid/ready request side carrying
// the operands and op, valid/ready result side carrying result and zero flag.
// Ports: slave = shifter side, master = requester/consumer side.
interface pipelined_shifter_if #(
   parameter int WIDTH = 32
);
   localparam int SHW = $clog2(WIDTH);

   // request side
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [2:0]       op;
   logic             use_const;
   logic [SHW-1:0]   constant_shift;

   // result side
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;

   modport slave (
      input  in_valid, a, b, op, use_const, constant_shift, out_ready,
      output in_ready, out_valid, result, zero
   );

   modport master (
      output in_valid, a, b, op, use_const, constant_shift, out_ready,
      input  in_ready, out_valid, result, zero
   );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (SRL/SRA/SLL/ROR/ROL/LUI/pass) with per-stage valid bits.
// Latency: exactly STAGES cycles accept->out_valid when unstalled; 1 op/cycle sustained.
// Backpressure: out_ready=0 holds result/zero; bubbles collapse; in_ready depends only on
// pipe state and out_ready (no in_valid->in_ready path).
// Ports: clk, reset (async active-high), bus (slave modport of pipelined_shifter_if).
module pipelined_shifter #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   pipelined_shifter_if.slave bus
);
   localparam int SHW   = $clog2(WIDTH);
   localparam int BASE  = SHW / STAGES;
   localparam int EXTRA = SHW % STAGES;

   typedef enum logic [2:0] {
      K_SRL = 3'd0,
      K_SRA = 3'd1,
      K_SLL = 3'd2,
      K_ROR = 3'd3,
      K_ROL = 3'd4
   } kind_e;

   // First mux level handled by stage k; earlier stages absorb the remainder levels.
   function automatic int lvl_lo(input int k);
      return k * BASE + ((k < EXTRA) ? k : EXTRA);
   endfunction

   function automatic int lvl_cnt(input int k);
      return BASE + ((k < EXTRA) ? 1 : 0);
   endfunction

   // Index of the register feeding stage k (clamped so stage 0 never forms index -1).
   function automatic int prev_idx(input int k);
      return (k == 0) ? 0 : k - 1;
   endfunction

   // One mux level: shift/rotate by 2**lvl.
   function automatic logic [WIDTH-1:0] shift_lvl(input logic [WIDTH-1:0] v,
                                                  input kind_e            t,
                                                  input int               lvl);
      int sh;
      sh = 1 << lvl;
      case (t)
         K_SRL:   return v >> sh;
         K_SRA:   return WIDTH'($signed(v) >>> sh);
         K_SLL:   return v << sh;
         K_ROR:   return (v >> sh) | (v << (WIDTH - sh));
         K_ROL:   return (v << sh) | (v >> (WIDTH - sh));
         default: return v;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Op decode: LUI becomes a left logical shift by WIDTH/2, pass (11x) becomes a
   // zero-amount shift, so the datapath only ever sees five shift kinds.
   // ---------------------------------------------------------------------------
   logic [SHW-1:0] sel_amt;
   logic [SHW-1:0] in_amt;
   kind_e          in_kind;

   assign sel_amt = bus.use_const ? bus.constant_shift : bus.a[SHW-1:0];

   always_comb begin
      in_kind = K_SLL;
      in_amt  = '0;
      case (bus.op)
         3'b000:  begin in_kind = K_SRL; in_amt = sel_amt; end
         3'b001:  begin in_kind = K_SRA; in_amt = sel_amt; end
         3'b010:  begin in_kind = K_SLL; in_amt = sel_amt; end
         3'b011:  begin in_kind = K_ROR; in_amt = sel_amt; end
         3'b100:  begin in_kind = K_ROL; in_amt = sel_amt; end
         3'b101:  begin in_kind = K_SLL; in_amt = SHW'(WIDTH / 2); end
         default: begin in_kind = K_SLL; in_amt = '0; end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Stage registers. amt_q holds only the not-yet-applied amount bits, realigned
   // so the next stage always finds its first level at bit 0.
   // ---------------------------------------------------------------------------
   logic [STAGES-1:0] vld_q;
   logic [WIDTH-1:0]  val_q  [STAGES];
   logic [SHW-1:0]    amt_q  [STAGES];
   kind_e             kind_q [STAGES];
   logic              zero_q;

   // Stage inputs and combinational stage outputs.
   logic [STAGES-1:0] stg_vld;
   logic [WIDTH-1:0]  nxt_v [STAGES];
   logic [SHW-1:0]    nxt_m [STAGES];
   kind_e             nxt_t [STAGES];
   logic [WIDTH-1:0]  cur_v;
   logic [SHW-1:0]    cur_m;
   kind_e             cur_t;

   always_comb begin
      stg_vld = '0;
      cur_v   = '0;
      cur_m   = '0;
      cur_t   = K_SLL;
      for (int k = 0; k < STAGES; k++) begin
         nxt_v[k] = '0;
         nxt_m[k] = '0;
         nxt_t[k] = K_SLL;
      end
      for (int k = 0; k < STAGES; k++) begin
         if (k == 0) begin
            stg_vld[k] = bus.in_valid;
            cur_v      = bus.b;
            cur_m      = in_amt;
            cur_t      = in_kind;
         end else begin
            stg_vld[k] = vld_q[prev_idx(k)];
            cur_v      = val_q[prev_idx(k)];
            cur_m      = amt_q[prev_idx(k)];
            cur_t      = kind_q[prev_idx(k)];
         end
         for (int j = 0; j < SHW; j++) begin
            if (j < lvl_cnt(k) && cur_m[j]) begin
               cur_v = shift_lvl(cur_v, cur_t, lvl_lo(k) + j);
            end
         end
         nxt_v[k] = cur_v;
         nxt_m[k] = cur_m >> lvl_cnt(k);
         nxt_t[k] = cur_t;
      end
   end

   // ---------------------------------------------------------------------------
   // Flow control: load[k] means stage k's register may take new contents this
   // edge, i.e. it is empty or its occupant is moving on. Walked from the output
   // back so each stage sees its successor's decision.
   // ---------------------------------------------------------------------------
   logic [STAGES-1:0] load;
   logic              down_ok;

   always_comb begin
      load    = '0;
      down_ok = bus.out_ready;
      for (int k = STAGES - 1; k >= 0; k--) begin
         load[k] = !vld_q[k] || down_ok;
         down_ok = load[k];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= '0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            val_q[k]  <= '0;
            amt_q[k]  <= '0;
            kind_q[k] <= K_SRL;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (load[k]) begin
               vld_q[k] <= stg_vld[k];
               // Bubbles advance the valid bit only, so data never churns on idle.
               if (stg_vld[k]) begin
                  val_q[k]  <= nxt_v[k];
                  amt_q[k]  <= nxt_m[k];
                  kind_q[k] <= nxt_t[k];
               end
            end
         end
         if (load[STAGES-1] && stg_vld[STAGES-1]) begin
            zero_q <= (nxt_v[STAGES-1] == '0);
         end
      end
   end

   assign bus.in_ready  = load[0];
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.result    = val_q[STAGES-1];
   assign bus.zero      = zero_q;

   // Upper a bits are architecturally ignored; the last stage's amount (always
   // fully consumed) and kind have no consumer.
   logic unused_ok;
   assign unused_ok = ^{bus.a[WIDTH-1:SHW], amt_q[STAGES-1], kind_q[STAGES-1]};

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=32, STAGES=2): arithmetic vectors,
// back-to-back throughput, stall/backpressure, mid-flight reset, amount-0 boundaries.
module tb_pipelined_shifter;
   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   pipelined_shifter_if #(.WIDTH(32)) bus ();

   pipelined_shifter #(.WIDTH(32), .STAGES(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv,
                        input logic uc, input logic [4:0] cs);
      bus.in_valid       = 1'b1;
      bus.op             = o;
      bus.a              = av;
      bus.b              = bv;
      bus.use_const      = uc;
      bus.constant_shift = cs;
   endtask

   // One isolated op into an empty pipe with out_ready=1; checks 2-cycle latency.
   task automatic run_one(input string tag, input logic [2:0] o, input logic [31:0] av,
                          input logic [31:0] bv, input logic uc, input logic [4:0] cs,
                          input logic [31:0] exp, input logic exp_zero);
      @(negedge clk);
      check({tag, " in_ready"}, bus.in_ready, 1);
      drive(o, av, bv, uc, cs);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.b        = ~bv;         // must not leak in: sampled only on accept
      bus.a        = 32'h0000_0007;
      check({tag, " vld@1"}, bus.out_valid, 0);
      @(negedge clk);
      check({tag, " vld@2"}, bus.out_valid, 1);
      check({tag, " result"}, bus.result, exp);
      check({tag, " zero"}, bus.zero, exp_zero);
   endtask

   // Back-to-back table
   logic [2:0]  bb_op  [8] = '{3'b010, 3'b000, 3'b011, 3'b100, 3'b001, 3'b101, 3'b110, 3'b000};
   logic [31:0] bb_a   [8] = '{32'd4, 32'd8, 32'd1, 32'd4, 32'd28, 32'd7, 32'd5, 32'd31};
   logic [31:0] bb_b   [8] = '{32'h0000_0001, 32'h0000_0100, 32'h0000_0001, 32'h8000_0000,
                               32'hF000_0000, 32'h0000_ABCD, 32'h1234_5678, 32'hFFFF_FFFF};
   logic [31:0] bb_exp [8] = '{32'h0000_0010, 32'h0000_0001, 32'h8000_0000, 32'h0000_0008,
                               32'hFFFF_FFFF, 32'hABCD_0000, 32'h1234_5678, 32'h0000_0001};

   initial begin
      int acc;
      reset              = 1'b1;
      bus.in_valid       = 1'b0;
      bus.out_ready      = 1'b1;
      bus.a              = '0;
      bus.b              = '0;
      bus.op             = '0;
      bus.use_const      = 1'b0;
      bus.constant_shift = '0;

      // Reset state
      #12;
      check("rst out_valid", bus.out_valid, 0);
      check("rst result", bus.result, 0);
      check("rst zero", bus.zero, 0);
      check("rst in_ready", bus.in_ready, 1);
      @(negedge clk);
      reset = 1'b0;

      // Arithmetic vectors
      run_one("sra",   3'b001, 32'd4,         32'h8000_00F0, 1'b0, 5'd0,  32'hF800_000F, 1'b0);
      run_one("srl",   3'b000, 32'd4,         32'h8000_00F0, 1'b0, 5'd0,  32'h0800_000F, 1'b0);
      run_one("lui",   3'b101, 32'd9,         32'h0000_1234, 1'b1, 5'd3,  32'h1234_0000, 1'b0);
      run_one("rol",   3'b100, 32'h21,        32'h8000_0001, 1'b0, 5'd0,  32'h0000_0003, 1'b0);
      run_one("ror",   3'b011, 32'd1,         32'h0000_0003, 1'b0, 5'd0,  32'h8000_0001, 1'b0);
      run_one("sllc",  3'b010, 32'd0,         32'h0000_0001, 1'b1, 5'd31, 32'h8000_0000, 1'b0);
      run_one("sra31", 3'b001, 32'd31,        32'h8000_0000, 1'b0, 5'd0,  32'hFFFF_FFFF, 1'b0);
      run_one("ror16", 3'b011, 32'd0,         32'h1234_ABCD, 1'b1, 5'd16, 32'hABCD_1234, 1'b0);
      run_one("luibe", 3'b101, 32'd0,         32'hDEAD_BEEF, 1'b0, 5'd0,  32'hBEEF_0000, 1'b0);
      run_one("sll0z", 3'b010, 32'd31,        32'h0000_0000, 1'b0, 5'd0,  32'h0000_0000, 1'b1);
      run_one("srlz",  3'b000, 32'd1,         32'h0000_0001, 1'b0, 5'd0,  32'h0000_0000, 1'b1);

      // Amount 0 (high a bits ignored) returns b for every op except LUI
      for (int i = 0; i < 8; i++) begin
         if (i != 5) begin
            run_one($sformatf("amt0 op%0d", i), 3'(i), 32'hFFFF_FFE0, 32'hDEAD_BEEF,
                    1'b0, 5'd0, 32'hDEAD_BEEF, 1'b0);
         end
      end

      // Back-to-back: 8 results on 8 consecutive cycles, in order
      @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         if (c >= 2) begin
            check($sformatf("b2b vld %0d", c - 2), bus.out_valid, 1);
            check($sformatf("b2b res %0d", c - 2), bus.result, bb_exp[c - 2]);
         end
         if (c < 8) begin
            check($sformatf("b2b in_ready %0d", c), bus.in_ready, 1);
            drive(bb_op[c], bb_a[c], bb_b[c], 1'b0, 5'd0);
         end else begin
            bus.in_valid = 1'b0;
         end
         @(negedge clk);
      end
      check("b2b drained", bus.out_valid, 0);

      // Stall: out_ready low for 5 cycles with in_valid held -> 2 accepts
      acc = 0;
      bus.out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         if (c == 0)      drive(3'b000, 32'd4,  32'h0000_00F0, 1'b0, 5'd0);
         else if (c == 1) drive(3'b010, 32'd28, 32'h0000_000F, 1'b0, 5'd0);
         else             drive(3'b010, 32'd1,  32'h5555_5555, 1'b0, 5'd0);
         if (bus.in_ready) acc++;
         if (c >= 2) begin
            check($sformatf("stall in_ready %0d", c), bus.in_ready, 0);
            check($sformatf("stall vld %0d", c), bus.out_valid, 1);
            check($sformatf("stall res %0d", c), bus.result, 32'h0000_000F);
         end
         @(negedge clk);
      end
      check("stall accepts", 32'(acc), 2);
      check("stall hold res", bus.result, 32'h0000_000F);
      check("stall hold zero", bus.zero, 0);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      check("drain vld", bus.out_valid, 1);
      check("drain res", bus.result, 32'hF000_0000);
      @(negedge clk);
      check("drain empty", bus.out_valid, 0);

      // Reset with two ops in flight
      drive(3'b010, 32'd3, 32'h0000_0001, 1'b0, 5'd0);
      @(negedge clk);
      drive(3'b010, 32'd4, 32'h0000_0001, 1'b0, 5'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("pre-rst vld", bus.out_valid, 1);
      check("pre-rst res", bus.result, 32'h0000_0008);
      reset = 1'b1;
      #1;
      check("mid-rst vld", bus.out_valid, 0);
      check("mid-rst res", bus.result, 0);
      check("mid-rst zero", bus.zero, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("post-rst vld %0d", c), bus.out_valid, 0);
         check($sformatf("post-rst res %0d", c), bus.result, 0);
      end
      run_one("after-rst", 3'b000, 32'd16, 32'hCAFE_0000, 1'b0, 5'd0, 32'h0000_CAFE, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
